// File: rtl/keypad_pkg.sv
// keypad_pkg: shared FSM/scan-result types, vending key codes and bit-count helpers for the keypad scanner
package keypad_pkg;
  typedef enum logic [1:0] {IDLE, CONFIRM, PRESSED} state_t;
  typedef enum logic [1:0] {NONE, SINGLE, MULTI} scan_t;
  localparam logic [3:0] KEY_OK = 4'hF;
  localparam logic [3:0] KEY_CONFIRM = 4'hE;
  localparam logic [3:0] KEY_TAKEN = 4'hD;
  localparam logic [3:0] KEY_COIN_0 = 4'h8;
  localparam logic [3:0] KEY_COIN_1 = 4'h9;
  localparam logic [3:0] KEY_COIN_2 = 4'hA;
  localparam logic [3:0] KEY_PROD_1 = 4'h1;
  localparam logic [3:0] KEY_PROD_2 = 4'h2;
  localparam logic [3:0] KEY_PROD_3 = 4'h3;
  localparam logic [3:0] KEY_PROD_4 = 4'h4;
  localparam logic [3:0] KEY_PROD_5 = 4'h5;
  function automatic logic [2:0] ones4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction
  function automatic logic [1:0] low_idx(input logic [3:0] v);
    return v[0] ? 2'd0 : v[1] ? 2'd1 : v[2] ? 2'd2 : 2'd3;
  endfunction
endpackage

// File: rtl/sync2_bus.sv
// sync2_bus: 4-bit 2-flop synchronizer, resets to 4'hF (clk, reset active-low async, d in, q out)
module sync2_bus (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] d,
  output logic [3:0] q
);
  logic [3:0] m;
  always_ff @(posedge clk or negedge reset)
    if (!reset) {q, m} <= 8'hFF;
    else {q, m} <= {m, d};
endmodule

// File: rtl/keypad_event_scanner.sv
// keypad_event_scanner: 4x4 keypad scan + debounce into single-shot events (in: clk, reset active-low async, row[3:0]; out: col[3:0], key_valid, key_code[3:0], key_held)
module keypad_event_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_held
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [3:0] DB = 4'(DEBOUNCE_SCANS);
  logic [3:0] row_s, hit, acc_code, code, cand, cnt, rel, next_cnt;
  logic [DW-1:0] div;
  logic [1:0] c, acc_n, n_tot;
  logic [2:0] sum;
  logic last, done, accept, rel_done;
  scan_t res;
  state_t state;
  sync2_bus u_sync (.clk(clk), .reset(reset), .d(row), .q(row_s));
  always_comb begin
    hit = ~row_s;
    last = div == DW'(SCAN_DIV - 1);
    done = last && c == 2'd3;
    sum = {1'b0, acc_n} + ones4(hit);
    n_tot = sum > 3'd1 ? 2'd2 : sum[1:0];
    code = acc_n == 2'd1 ? acc_code : {low_idx(hit), c};
    res = n_tot == 2'd0 ? NONE : n_tot == 2'd1 ? SINGLE : MULTI;
    next_cnt = state == CONFIRM && code == cand ? cnt + 4'd1 : 4'd1;
    accept = done && res == SINGLE && state != PRESSED && next_cnt == DB;
    rel_done = done && state == PRESSED && res == NONE && rel + 4'd1 == DB;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      div <= '0;
      c <= '0;
      col <= 4'b1110;
      acc_n <= '0;
      acc_code <= '0;
    end else begin
      div <= last ? '0 : div + DW'(1);
      if (last) begin
        c <= c + 2'd1;
        col <= {col[2:0], col[3]};
        acc_n <= done ? 2'd0 : n_tot;
        acc_code <= code;
      end
    end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cand <= '0;
      cnt <= '0;
      rel <= '0;
      key_valid <= 1'b0;
      key_code <= '0;
      key_held <= 1'b0;
    end else begin
      key_valid <= accept;
      if (accept) begin
        key_code <= code;
        key_held <= 1'b1;
        state <= PRESSED;
        cnt <= '0;
        rel <= '0;
      end else if (rel_done) begin
        key_held <= 1'b0;
        state <= IDLE;
        rel <= '0;
      end else if (done && state != PRESSED) begin
        state <= res == SINGLE ? CONFIRM : IDLE;
        cand <= res == SINGLE ? code : cand;
        cnt <= res == SINGLE ? next_cnt : 4'd0;
      end else if (done) begin
        rel <= res == NONE ? rel + 4'd1 : 4'd0;
      end
    end
endmodule

// File: doc/keypad_event_scanner.md
# keypad_event_scanner

Scans the 4x4 membrane keypad and turns raw row/column contacts into clean, debounced, single-shot key events. It sits directly upstream of the vending-machine controller FSM. Each physical press yields exactly one `key_valid` pulse with a stable 4-bit `key_code`, so the controller never sees a key repeat or bounce. It replaces the separate scan, debounce and count paths with one block.

## Interface
Parameters:
- `SCAN_DIV`, default 1000: clk cycles each column stays driven; must be ≥ 4.
- `DEBOUNCE_SCANS`, default 4: consecutive identical full scans required to accept a press or a release; range 1..15.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  reset, asynchronous, active-low.
- `row`  in  4  raw keypad rows, active-low (pulled up), asynchronous to clk.
- `col`  out  4  column drive, active-low, exactly one bit low at any time.
- `key_valid`  out  1  one-cycle pulse when a press is accepted.
- `key_code`  out  4  code of the last accepted key; held until the next accepted press.
- `key_held`  out  1  high from acceptance until the release is accepted.

## Operation
- Row input passes through a 2-flop synchronizer before any use.
- Column pointer `c` steps 0→1→2→3→0. `col = ~(4'b0001 << c)`. Each column is held for `SCAN_DIV` cycles.
- Synced rows are sampled on the last cycle of each column dwell. Sampling on that last cycle gives settle time after the column change.
- Full-scan result after column 3: NONE (no row low on any column), SINGLE(code) (exactly one contact across all 4 columns), or MULTI (two or more contacts).
- Code mapping: `code = {row_idx[1:0], col_idx[1:0]}`, i.e. row*4+col. Row 3/col 3 is 4'hF (OK) and row 3/col 2 is 4'hE (CONFIRM).
- FSM states, updated once per full scan:
  - IDLE: on SINGLE(k), latch the candidate k, set `cnt=1`, and go to CONFIRM. If `DEBOUNCE_SCANS=1`, accept immediately instead. NONE or MULTI keeps the FSM in IDLE.
  - CONFIRM: on SINGLE(k) equal to the candidate, `cnt++`. When `cnt` reaches `DEBOUNCE_SCANS`, accept. On SINGLE with a different key, restart CONFIRM with the new candidate and `cnt=1`. On NONE or MULTI, go to IDLE.
  - Accepting a key: `key_code<=k`, `key_valid` pulses, `key_held<=1`, and the FSM goes to PRESSED.
  - PRESSED: each NONE scan increments the release count; any SINGLE or MULTI scan clears it. When the release count reaches `DEBOUNCE_SCANS`, `key_held<=0` and the FSM goes to IDLE. No event is emitted while in PRESSED, including when a second key is added or the key is changed.
- Reset mid-operation clears everything immediately, with no pending pulse.
- Reset values: `col=4'b1110`, `key_valid=0`, `key_code=4'h0`, `key_held=0`, FSM in IDLE, pointer 0, all counters 0.

## Timing
- Scan period is `4*SCAN_DIV` cycles. The scan completes on the last cycle of column 3.
- `key_valid` is registered. It is high for exactly one cycle, in the cycle after the completing scan's final sample. `key_code` is valid in that same cycle.
- Press latency: a press held stable from before the start of a scan asserts `key_valid` `DEBOUNCE_SCANS*4*SCAN_DIV + 1` cycles after that scan starts, plus up to 2 cycles of synchronizer delay.
- Row must be stable for ≥ 3 cycles before a sample edge to be captured deterministically.
- `key_held` falls in the same cycle position as `key_valid`, relative to the accepting release scan.
- Minimum spacing between two `key_valid` pulses is `2*DEBOUNCE_SCANS` scans.

## Structure
- Shared package `keypad_pkg`:
  - FSM state enum (IDLE, CONFIRM, PRESSED).
  - Scan-result enum (NONE, SINGLE, MULTI).
  - Named key-code constants: KEY_OK=4'hF, KEY_CONFIRM=4'hE, KEY_TAKEN=4'hD, coin keys 4'h8/4'h9/4'hA, product keys 4'h1..4'h5.
- One sub-module, `sync2_bus`: a 2-flop synchronizer, 4 bits wide, with async active-low reset to 4'hF. All other logic is in this block.

## Test plan
All scenarios use `SCAN_DIV=4` and `DEBOUNCE_SCANS=3`, so a scan is 16 cycles.
- Hold row1/col2 (code 4'h6) low for 10 scans, then release → exactly one `key_valid` with `key_code=4'h6`, 49 ±2 cycles after press. `key_held` is high until 3 NONE scans after release.
- Press 4'hF that bounces (toggling every 5 cycles for 2 scans), then holds stable → no pulse during the bounce, one pulse after 3 clean scans.
- Press 4'h8 and 4'h9 together from IDLE for 8 scans → no `key_valid`. Release 4'h9 → one pulse with code 4'h8.
- Hold 4'h1 until accepted, then add 4'h2 while still holding → no second pulse. Release both, then press 4'h2 → pulse with code 4'h2.
- Assert reset for 1 cycle during the CONFIRM scan count → outputs return to their reset values, `col=4'b1110`, and no pulse is emitted later for that press unless it is re-debounced from scratch.
- Apply 2-scan presses separated by 1-scan gaps (below the threshold) → zero events. `col` never has more than one low bit at any time.
